prog_switch_matrix: RTL and testbench

//  Parametrised routing matrix for a logic tile. Selects NUM_OUT signals from NUM_IN routing

---
 rtl/prog_switch_matrix.sv | 108 ++++++++++
 tb/tb_prog_switch_matrix.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_switch_matrix.sv
// Programmable routing matrix. It picks NUM_OUT signals from NUM_IN tracks. A serial scan chain
// loads a shadow register, and a commit copies that shadow into the active routing config.
module prog_switch_matrix #(
   parameter int NUM_IN  = 16,
   parameter int NUM_OUT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prog_in,
   input  logic               prog_en,
   input  logic               prog_load,
   input  logic [NUM_IN-1:0]  in,
   output logic               prog_out,
   output logic [NUM_OUT-1:0] out,
   output logic               cfg_valid,
   output logic               prog_done,
   output logic               prog_err
);

   localparam int SEL_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int CFG_BITS = NUM_OUT * (SEL_W + 1);
   localparam int CNT_W    = $clog2(CFG_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_OUT-1:0]  out_q, out_d;
   logic                cfg_valid_q, cfg_valid_d;
   logic                prog_done_q, prog_done_d;
   logic                prog_err_q, prog_err_d;
   logic [NUM_OUT-1:0]  mux;

   // Config control. A load is accepted only when exactly one of shift and load is requested.
   always_comb begin
      shadow_d    = shadow_q;
      active_d    = active_q;
      cnt_d       = cnt_q;
      cfg_valid_d = cfg_valid_q;
      prog_done_d = 1'b0;
      prog_err_d  = 1'b0;
      case ({prog_en, prog_load})
         2'b10: begin
            shadow_d = {shadow_q[CFG_BITS-2:0], prog_in};
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
         end
         2'b01: begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
               active_d    = shadow_q;
               cfg_valid_d = 1'b1;
               prog_done_d = 1'b1;
            end else begin
               prog_err_d = 1'b1;
            end
         end
         2'b11: begin
            cnt_d      = '0;
            prog_err_d = 1'b1;
         end
         default: ;
      endcase
   end

   // A select value with no matching track leaves the output at 0.
   always_comb begin
      mux = '0;
      for (int j = 0; j < NUM_OUT; j++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (active_q[j*SEL_W +: SEL_W] == SEL_W'(i)) mux[j] = in[i];
         end
      end
   end

   always_comb begin
      out_d = mux;
      out   = '0;
      for (int j = 0; j < NUM_OUT; j++) begin
         out[j] = cfg_valid_q & (active_q[NUM_OUT*SEL_W + j] ? out_q[j] : mux[j]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q    <= '0;
         active_q    <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         cfg_valid_q <= 1'b0;
         prog_done_q <= 1'b0;
         prog_err_q  <= 1'b0;
      end else begin
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         cfg_valid_q <= cfg_valid_d;
         prog_done_q <= prog_done_d;
         prog_err_q  <= prog_err_d;
      end
   end

   assign prog_out  = shadow_q[CFG_BITS-1];
   assign cfg_valid = cfg_valid_q;
   assign prog_done = prog_done_q;
   assign prog_err  = prog_err_q;

endmodule

// File: tb/tb_prog_switch_matrix.sv
// Directed bench for prog_switch_matrix. Two default tiles are chained (t0 feeds t1), and a
// NUM_IN=12 tile shares the same config controls.
module tb_prog_switch_matrix;

   logic        clk = 1'b0;
   logic        rst;
   logic        prog_in, prog_en, prog_load;
   logic [15:0] in_bus;

   logic       t0_prog_out, t0_cfg_valid, t0_prog_done, t0_prog_err;
   logic       t1_prog_out, t1_cfg_valid, t1_prog_done, t1_prog_err;
   logic       n12_prog_out, n12_cfg_valid, n12_prog_done, n12_prog_err;
   logic [3:0] t0_out, t1_out, n12_out;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prog_switch_matrix u_t0 (
      .clk(clk), .rst(rst), .prog_in(prog_in), .prog_en(prog_en), .prog_load(prog_load),
      .in(in_bus), .prog_out(t0_prog_out), .out(t0_out), .cfg_valid(t0_cfg_valid),
      .prog_done(t0_prog_done), .prog_err(t0_prog_err)
   );

   prog_switch_matrix u_t1 (
      .clk(clk), .rst(rst), .prog_in(t0_prog_out), .prog_en(prog_en), .prog_load(prog_load),
      .in(in_bus), .prog_out(t1_prog_out), .out(t1_out), .cfg_valid(t1_cfg_valid),
      .prog_done(t1_prog_done), .prog_err(t1_prog_err)
   );

   prog_switch_matrix #(.NUM_IN(12), .NUM_OUT(4)) u_n12 (
      .clk(clk), .rst(rst), .prog_in(prog_in), .prog_en(prog_en), .prog_load(prog_load),
      .in(in_bus[11:0]), .prog_out(n12_prog_out), .out(n12_out), .cfg_valid(n12_cfg_valid),
      .prog_done(n12_prog_done), .prog_err(n12_prog_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Config word layout: {rmod3..0, sel3, sel2, sel1, sel0}. The MSB is shifted first.
   task automatic shift_word(input logic [19:0] w);
      for (int i = 19; i >= 0; i--) begin
         prog_in = w[i];
         prog_en = 1'b1;
         tick();
      end
      prog_en = 1'b0;
      prog_in = 1'b0;
   endtask

   task automatic shift_const(input logic b, input int n);
      for (int i = 0; i < n; i++) begin
         prog_in = b;
         prog_en = 1'b1;
         tick();
      end
      prog_en = 1'b0;
      prog_in = 1'b0;
   endtask

   task automatic load();
      prog_load = 1'b1;
      tick();
      prog_load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; prog_in = 1'b0; prog_en = 1'b0; prog_load = 1'b0; in_bus = 16'hFFFF;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_out", 32'(t0_out), 32'h0);
      check("rst_cfg_valid", 32'(t0_cfg_valid), 32'h0);
      check("rst_prog_out", 32'(t0_prog_out), 32'h0);
      check("rst_done_err", 32'({t0_prog_done, t0_prog_err}), 32'h0);
      check("rst_n12_out", 32'(n12_out), 32'h0);

      // Identity routing, combinational
      shift_word(20'h03210);
      load();
      check("load_done", 32'(t0_prog_done), 32'h1);
      check("load_cfg_valid", 32'(t0_cfg_valid), 32'h1);
      check("ident_ffff", 32'(t0_out), 32'hF);
      in_bus = 16'h000A;
      #1;
      check("ident_000a", 32'(t0_out), 32'hA);
      tick();
      check("done_pulse_end", 32'(t0_prog_done), 32'h0);

      // Short shift is rejected, and the counter restarts
      shift_const(1'b1, 12);
      load();
      check("short_err", 32'(t0_prog_err), 32'h1);
      check("short_no_done", 32'(t0_prog_done), 32'h0);
      check("short_active_kept", 32'(t0_out), 32'hA);
      tick();
      check("err_pulse_end", 32'(t0_prog_err), 32'h0);
      shift_const(1'b0, 8);
      load();
      check("cnt_cleared_err", 32'(t0_prog_err), 32'h1);

      // Simultaneous shift and load: error, no shift, counter cleared
      shift_word(20'h83215);
      check("shadow_msb", 32'(t0_prog_out), 32'h1);
      prog_en = 1'b1; prog_load = 1'b1; prog_in = 1'b0;
      tick();
      prog_en = 1'b0; prog_load = 1'b0;
      check("both_err", 32'(t0_prog_err), 32'h1);
      check("both_no_shift", 32'(t0_prog_out), 32'h1);
      load();
      check("both_cnt_cleared", 32'(t0_prog_err), 32'h1);
      check("both_active_kept", 32'(t0_out), 32'hA);

      // out[0] registered on in[5]; out[3:1] combinational on in[3:1]
      shift_word(20'h13215);
      load();
      check("reg_load_done", 32'(t0_prog_done), 32'h1);
      in_bus = 16'h0000;
      tick();
      check("reg_zero", 32'(t0_out), 32'h0);
      in_bus = 16'h002E;
      #1;
      check("reg_rise_same", 32'(t0_out), 32'hE);
      tick();
      check("reg_rise_next", 32'(t0_out), 32'hF);
      in_bus = 16'h0000;
      #1;
      check("reg_fall_same", 32'(t0_out), 32'h1);
      tick();
      check("reg_fall_next", 32'(t0_out), 32'h0);

      // Two chained tiles: the first 20 bits shifted land in t1
      shift_word(20'h07654);
      shift_word(20'h0BA98);
      check("chain_prog_out", 32'(t0_prog_out), 32'h0);
      load();
      check("chain_t0_done", 32'(t0_prog_done), 32'h1);
      check("chain_t1_done", 32'(t1_prog_done), 32'h1);
      in_bus = 16'h0A50;
      #1;
      check("chain_t0_out", 32'(t0_out), 32'hA);
      check("chain_t1_out", 32'(t1_out), 32'h5);

      // A load during a shift is rejected
      prog_en = 1'b1; prog_in = 1'b1;
      tick(); tick();
      prog_load = 1'b1;
      tick();
      prog_load = 1'b0;
      check("mid_load_t0_err", 32'(t0_prog_err), 32'h1);
      check("mid_load_t1_err", 32'(t1_prog_err), 32'h1);
      check("mid_load_t0_out", 32'(t0_out), 32'hA);
      check("mid_load_t1_out", 32'(t1_out), 32'h5);

      // Reset in the middle of a shift
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; prog_en = 1'b0; prog_in = 1'b0;
      check("rst_mid_valid", 32'({t0_cfg_valid, t1_cfg_valid}), 32'h0);
      check("rst_mid_out", 32'({t0_out, t1_out}), 32'h0);
      check("rst_mid_prog_out", 32'(t0_prog_out), 32'h0);
      check("rst_mid_err", 32'(t0_prog_err), 32'h0);
      load();
      check("rst_mid_cnt", 32'(t0_prog_err), 32'h1);
      check("rst_mid_still_invalid", 32'(t0_cfg_valid), 32'h0);

      // NUM_IN=12: the counter saturates over 25 shifts, and an out-of-range select gives 0
      shift_const(1'b1, 5);
      shift_word(20'h0E3B0);
      load();
      check("n12_done", 32'(n12_prog_done), 32'h1);
      check("n12_valid", 32'(n12_cfg_valid), 32'h1);
      in_bus = 16'h0FFF;
      #1;
      check("n12_out_fff", 32'(n12_out), 32'h7);
      in_bus = 16'h0008;
      #1;
      check("n12_out_008", 32'(n12_out), 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
